clb_config_serializer: RTL and testbench

Bitstream front-end that feeds the serial configuration port of a chain of CLB config shift registers. Accepts byte-wide configuration data over a valid/ready handshake, converts it to one bit per clock on bit_out, and drives the programming controls: prgm_b, clb_prgm_b, and the chain-head enable. Pauses downstream shifting on data underflow. Releases the chain into user mode once NUM_CLB*FRAME_BITS bits have been delivered.

---
 rtl/cfg_pkg.sv | 34 +++
 rtl/cfg_byte_buffer.sv | 77 +++++++
 rtl/clb_config_serializer.sv | 248 ++++++++++++++++++++++++
 tb/tb_clb_config_serializer.sv | 324 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cfg_pkg.sv
`default_nettype none
// ============================================================================
// Module   : cfg_pkg
// Purpose  : Shared types and constants for the CLB configuration serializer
// Revision : 1.0  initial release
// ============================================================================
package cfg_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ARM     = 3'd1,
        ST_LOAD    = 3'd2,
        ST_RELEASE = 3'd3,
        ST_DONE    = 3'd4,
        ST_ERR     = 3'd5
    } cfg_state_e;

    localparam int         CLB_FRAME_BITS = 37;
    localparam int         LUT_BITS       = 16;
    localparam int         ICONN_BITS     = 20;
    localparam logic [7:0] CRC8_POLY      = 8'h07;

    // Byte-at-a-time CRC-8, MSB first, no reflection, no final xor
    function automatic logic [7:0] crc8_update(input logic [7:0] crc, input logic [7:0] data);
        logic [7:0] c;
        c = crc ^ data;
        for (int i = 0; i < 8; i++) begin
            c = c[7] ? ((c << 1) ^ CRC8_POLY) : (c << 1);
        end
        return c;
    endfunction

endpackage
`default_nettype wire

// File: rtl/cfg_byte_buffer.sv
`default_nettype none
// ============================================================================
// Module   : cfg_byte_buffer
// Purpose  : Two-entry ping-pong byte buffer, valid/ready in, pop/empty out
// Revision : 1.0  initial release
// ============================================================================
module cfg_byte_buffer #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              pop,
    output logic [DATA_W-1:0] out_data,
    output logic              out_empty
);

    logic [DATA_W-1:0] mem_q [2];
    logic [DATA_W-1:0] mem_d [2];
    logic              wr_ptr_q, wr_ptr_d;
    logic              rd_ptr_q, rd_ptr_d;
    logic [1:0]        count_q, count_d;
    logic              push_en;
    logic              pop_en;

    assign in_ready  = (count_q != 2'd2);
    assign out_empty = (count_q == 2'd0);
    assign out_data  = mem_q[rd_ptr_q];

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        push_en  = in_valid && in_ready;
        pop_en   = pop && !out_empty;

        if (push_en) begin
            mem_d[wr_ptr_q] = in_data;
            wr_ptr_d        = ~wr_ptr_q;
        end
        if (pop_en) begin
            rd_ptr_d = ~rd_ptr_q;
        end
        case ({push_en, pop_en})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase

        if (flush) begin
            wr_ptr_d = 1'b0;
            rd_ptr_d = 1'b0;
            count_d  = 2'd0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/clb_config_serializer.sv
`default_nettype none
// ============================================================================
// Module   : clb_config_serializer
// Purpose  : Byte-to-bit front-end driving the CLB configuration shift chain.
//            Optional CRC-8 trailer check enabled by defining CFG_CRC_EN.
// Revision : 1.0  initial release
// ============================================================================
module clb_config_serializer
    import cfg_pkg::*;
#(
    parameter int NUM_CLB    = 4,
    parameter int FRAME_BITS = CLB_FRAME_BITS,
    parameter int DATA_W     = 8,
    parameter int CNT_W      = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [DATA_W-1:0] cfg_data,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    output logic              bit_out,
    output logic              prgm_b,
    output logic              clb_prgm_b,
    output logic              chain_en,
    output logic              busy,
    output logic              done,
`ifdef CFG_CRC_EN
    output logic              crc_err,
`endif
    output logic [CNT_W-1:0]  bit_cnt
);

    localparam int               TOTAL_BITS    = NUM_CLB * FRAME_BITS;
    localparam int               PAYLOAD_BYTES = (TOTAL_BITS + DATA_W - 1) / DATA_W;
    localparam int               IDX_W         = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [CNT_W-1:0] TOTAL_C       = CNT_W'(TOTAL_BITS);
    localparam logic [CNT_W-1:0] PAYLOAD_C     = CNT_W'(PAYLOAD_BYTES);
    localparam logic [IDX_W-1:0] IDX_LAST      = IDX_W'(DATA_W - 1);

    cfg_state_e        state_q, state_d;
    logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
    logic [CNT_W-1:0]  acc_cnt_q, acc_cnt_d;
    logic [IDX_W-1:0]  bit_idx_q, bit_idx_d;
    logic              bit_out_q, bit_out_d;
    logic              prgm_b_q, prgm_b_d;
    logic              clb_prgm_b_q, clb_prgm_b_d;
    logic              chain_en_q, chain_en_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;

    logic              buf_in_valid;
    logic              buf_in_ready;
    logic              buf_pop;
    logic              buf_flush;
    logic [DATA_W-1:0] buf_data;
    logic              buf_empty;
    logic [DATA_W-1:0] head_shift;

    logic              accepting_state;
    logic              payload_slot;
    logic              crc_slot;
    logic              accept;
    logic              emit;
    logic              last_bit;

`ifdef CFG_CRC_EN
    logic [7:0]        crc_q, crc_d;
    logic [7:0]        crc_rx_q, crc_rx_d;
    logic              crc_have_q, crc_have_d;
    logic              crc_err_q, crc_err_d;
    logic              stream_end;

    // The trailer byte bypasses the buffer so it never competes with payload slots
    assign crc_slot = (acc_cnt_q == PAYLOAD_C);
    assign crc_err  = crc_err_q;
`else
    assign crc_slot = 1'b0;
`endif

    assign accepting_state = (state_q == ST_ARM) || (state_q == ST_LOAD);
    assign payload_slot    = (acc_cnt_q < PAYLOAD_C);
    assign cfg_ready       = accepting_state && ((payload_slot && buf_in_ready) || crc_slot);
    assign accept          = cfg_valid && cfg_ready;
    assign buf_in_valid    = accept && payload_slot;

    assign head_shift = buf_data << bit_idx_q;
    assign emit       = (state_q == ST_LOAD) && (bit_cnt_q != TOTAL_C) && !buf_empty;
    assign last_bit   = (bit_cnt_q == (TOTAL_C - CNT_W'(1)));

    cfg_byte_buffer #(
        .DATA_W (DATA_W)
    ) u_buf (
        .clk       (clk),
        .reset     (reset),
        .flush     (buf_flush),
        .in_data   (cfg_data),
        .in_valid  (buf_in_valid),
        .in_ready  (buf_in_ready),
        .pop       (buf_pop),
        .out_data  (buf_data),
        .out_empty (buf_empty)
    );

    always_comb begin
        state_d      = state_q;
        bit_cnt_d    = bit_cnt_q;
        acc_cnt_d    = acc_cnt_q;
        bit_idx_d    = bit_idx_q;
        bit_out_d    = bit_out_q;
        prgm_b_d     = prgm_b_q;
        clb_prgm_b_d = 1'b0;
        chain_en_d   = chain_en_q;
        busy_d       = busy_q;
        done_d       = 1'b0;
        buf_pop      = 1'b0;
        buf_flush    = 1'b0;
`ifdef CFG_CRC_EN
        crc_d      = crc_q;
        crc_rx_d   = crc_rx_q;
        crc_have_d = crc_have_q;
        crc_err_d  = crc_err_q;
        stream_end = (emit && last_bit) || (bit_cnt_q == TOTAL_C);
        if (accept) begin
            if (payload_slot) begin
                crc_d = crc8_update(crc_q, 8'(cfg_data));
            end else begin
                crc_rx_d   = 8'(cfg_data);
                crc_have_d = 1'b1;
            end
        end
`endif
        if (accept) begin
            acc_cnt_d = acc_cnt_q + CNT_W'(1);
        end

        case (state_q)
            ST_IDLE, ST_DONE, ST_ERR: begin
                if (start) begin
                    state_d    = ST_ARM;
                    bit_cnt_d  = '0;
                    acc_cnt_d  = '0;
                    bit_idx_d  = '0;
                    prgm_b_d   = 1'b0;
                    chain_en_d = 1'b1;
                    busy_d     = 1'b1;
                    buf_flush  = 1'b1;
`ifdef CFG_CRC_EN
                    crc_d      = 8'h00;
                    crc_have_d = 1'b0;
                    crc_err_d  = 1'b0;
`endif
                end
            end
            ST_ARM: begin
                state_d = ST_LOAD;
            end
            ST_LOAD: begin
                // On underflow nothing is consumed and bit_out keeps its value
                if (emit) begin
                    bit_out_d    = head_shift[DATA_W-1];
                    clb_prgm_b_d = 1'b1;
                    bit_cnt_d    = bit_cnt_q + CNT_W'(1);
                    if (last_bit || (bit_idx_q == IDX_LAST)) begin
                        buf_pop   = 1'b1;
                        bit_idx_d = '0;
                    end else begin
                        bit_idx_d = bit_idx_q + IDX_W'(1);
                    end
                end
`ifdef CFG_CRC_EN
                if (stream_end && crc_have_q) begin
                    if (crc_rx_q == crc_q) begin
                        state_d = ST_RELEASE;
                    end else begin
                        state_d    = ST_ERR;
                        busy_d     = 1'b0;
                        chain_en_d = 1'b0;
                        crc_err_d  = 1'b1;
                    end
                end
`else
                if (emit && last_bit) begin
                    state_d = ST_RELEASE;
                end
`endif
            end
            ST_RELEASE: begin
                state_d    = ST_DONE;
                prgm_b_d   = 1'b1;
                chain_en_d = 1'b0;
                busy_d     = 1'b0;
                done_d     = 1'b1;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            bit_cnt_q    <= '0;
            acc_cnt_q    <= '0;
            bit_idx_q    <= '0;
            bit_out_q    <= 1'b0;
            prgm_b_q     <= 1'b1;
            clb_prgm_b_q <= 1'b0;
            chain_en_q   <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
`ifdef CFG_CRC_EN
            crc_q        <= 8'h00;
            crc_rx_q     <= 8'h00;
            crc_have_q   <= 1'b0;
            crc_err_q    <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            bit_cnt_q    <= bit_cnt_d;
            acc_cnt_q    <= acc_cnt_d;
            bit_idx_q    <= bit_idx_d;
            bit_out_q    <= bit_out_d;
            prgm_b_q     <= prgm_b_d;
            clb_prgm_b_q <= clb_prgm_b_d;
            chain_en_q   <= chain_en_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
`ifdef CFG_CRC_EN
            crc_q        <= crc_d;
            crc_rx_q     <= crc_rx_d;
            crc_have_q   <= crc_have_d;
            crc_err_q    <= crc_err_d;
`endif
        end
    end

    assign bit_out    = bit_out_q;
    assign prgm_b     = prgm_b_q;
    assign clb_prgm_b = clb_prgm_b_q;
    assign chain_en   = chain_en_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign bit_cnt    = bit_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_clb_config_serializer.sv
`default_nettype none
// ============================================================================
// Module   : tb_clb_config_serializer
// Purpose  : Randomized self-checking bench for clb_config_serializer
//            (CRC scenarios active when CFG_CRC_EN is defined)
// Revision : 1.0  initial release
// ============================================================================
module tb_clb_config_serializer;

    localparam int NUM_CLB = 4;
    localparam int FRAME   = 37;
    localparam int DATA_W  = 8;
    localparam int CNT_W   = 16;
    localparam int TOTAL   = NUM_CLB * FRAME;
    localparam int PAYLOAD = (TOTAL + DATA_W - 1) / DATA_W;
`ifdef CFG_CRC_EN
    localparam int N_ACC   = PAYLOAD + 1;
`else
    localparam int N_ACC   = PAYLOAD;
`endif

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic              start = 1'b0;
    logic [DATA_W-1:0] cfg_data = '0;
    logic              cfg_valid = 1'b0;
    logic              cfg_ready, bit_out, prgm_b, clb_prgm_b, chain_en, busy, done;
    logic [CNT_W-1:0]  bit_cnt;
`ifdef CFG_CRC_EN
    logic              crc_err;
`endif

    clb_config_serializer #(
        .NUM_CLB(NUM_CLB), .FRAME_BITS(FRAME), .DATA_W(DATA_W), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .cfg_data(cfg_data),
        .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .bit_out(bit_out),
        .prgm_b(prgm_b), .clb_prgm_b(clb_prgm_b), .chain_en(chain_en),
        .busy(busy), .done(done),
`ifdef CFG_CRC_EN
        .crc_err(crc_err),
`endif
        .bit_cnt(bit_cnt)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [7:0] payload_q [$];
    bit         cap_stream [$];
    int  n_en, n_gap, n_hold_err, n_done, n_nonmono, n_accepted;
    int  cyc_first_en, cyc_last_en, cyc_done;
    bit  timed_out, saw_crc_err, mon_done, rst_hit;
    logic [6:0]       rst_snap_ctl;
    logic [CNT_W-1:0] rst_snap_cnt;

    // Expected stream bit s: MSB-first bit of the payload byte holding it
    function automatic bit exp_bit(input int s);
        logic [7:0] b;
        b = payload_q[s / 8];
        return b[7 - (s % 8)];
    endfunction

    // Bit-serial LFSR form of CRC-8 poly 0x07, init 0
    function automatic logic [7:0] ref_crc8();
        logic [7:0] crc;
        logic [7:0] b;
        bit fb;
        crc = 8'h00;
        foreach (payload_q[j]) begin
            b = payload_q[j];
            for (int i = 7; i >= 0; i--) begin
                fb  = crc[7] ^ b[i];
                crc = {crc[6:0], 1'b0} ^ (fb ? 8'h07 : 8'h00);
            end
        end
        return crc;
    endfunction

    task automatic build_payload(input bit fixed_head);
        payload_q.delete();
        for (int i = 0; i < PAYLOAD; i++) payload_q.push_back(8'($urandom));
        if (fixed_head) begin
            payload_q[0] = 8'hFF; payload_q[1] = 8'h00; payload_q[2] = 8'hAA;
            payload_q[3] = 8'h55; payload_q[4] = 8'hC0;
        end
    endtask

    function automatic int stream_mismatches();
        int m;
        m = 0;
        for (int s = 0; s < TOTAL; s++) begin
            if (s >= cap_stream.size()) m++;
            else if (cap_stream[s] != exp_bit(s)) m++;
        end
        return m;
    endfunction

    task automatic run_pass(input int stall_after, input int stall_len, input int start_at_en,
                            input int reset_at_cnt, input int extra_bytes, input bit bad_crc);
        logic [7:0] tx_q [$];
        tx_q = payload_q;
`ifdef CFG_CRC_EN
        tx_q.push_back(bad_crc ? (ref_crc8() ^ 8'h5A) : ref_crc8());
`else
        if (bad_crc) tx_q.push_back(8'h00);
`endif
        for (int i = 0; i < extra_bytes; i++) tx_q.push_back(8'($urandom));
        cap_stream.delete();
        n_en = 0; n_gap = 0; n_hold_err = 0; n_done = 0; n_nonmono = 0; n_accepted = 0;
        cyc_first_en = -1; cyc_last_en = -1; cyc_done = -1;
        timed_out = 0; saw_crc_err = 0; mon_done = 0; rst_hit = 0;
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        fork
            begin : producer
                int idx, stall_left;
                idx = 0; stall_left = 0;
                while (!mon_done) begin
                    if (idx < tx_q.size() && stall_left == 0) begin
                        cfg_valid = 1'b1;
                        cfg_data  = tx_q[idx];
                    end else begin
                        cfg_valid = 1'b0;
                    end
                    if (stall_left > 0) stall_left--;
                    if (cfg_valid && cfg_ready) begin
                        idx++;
                        n_accepted++;
                        if (idx == stall_after && stall_len > 0) stall_left = stall_len;
                    end
                    @(negedge clk);
                end
                cfg_valid = 1'b0;
            end
            begin : monitor
                int lim, post;
                bit prev_bit, started;
                logic [CNT_W-1:0] prev_cnt;
                lim = 0; post = 0; prev_bit = 1'b0; started = 0; prev_cnt = '0;
                while (1) begin
                    if (reset_at_cnt >= 0 && int'(bit_cnt) == reset_at_cnt) begin
                        reset = 1'b1;
                        #1;
                        rst_snap_ctl = {cfg_ready, bit_out, prgm_b, clb_prgm_b, chain_en, busy, done};
                        rst_snap_cnt = bit_cnt;
                        rst_hit = 1;
                        break;
                    end
                    if (clb_prgm_b) begin
                        cap_stream.push_back(bit_out);
                        if (n_en == 0) cyc_first_en = lim;
                        n_en++;
                        cyc_last_en = lim;
                        prev_bit = bit_out;
                    end else if (n_en > 0 && n_done == 0 && busy) begin
                        n_gap++;
                        if (bit_out !== prev_bit) n_hold_err++;
                    end
                    if (busy && bit_cnt < prev_cnt) n_nonmono++;
                    prev_cnt = bit_cnt;
                    if (done) begin n_done++; cyc_done = lim; end
`ifdef CFG_CRC_EN
                    if (crc_err) saw_crc_err = 1;
`endif
                    if (start_at_en >= 0 && n_en == start_at_en && !started) begin
                        start = 1'b1; started = 1;
                    end else begin
                        start = 1'b0;
                    end
                    if (n_done > 0 || saw_crc_err) post++;
                    if (post > 4) break;
                    lim++;
                    if (lim > 3000) begin timed_out = 1; break; end
                    @(negedge clk);
                end
                start = 1'b0;
                mon_done = 1;
            end
        join
    endtask

    task automatic check_good_pass(input string tag);
        checks++;
        if (timed_out !== 1'b0) begin errors++; $display("FAIL %s timeout: got %0d required 0", tag, timed_out); end
        checks++;
        if (n_en !== TOTAL) begin errors++; $display("FAIL %s enable_cycles: got %0d required %0d", tag, n_en, TOTAL); end
        checks++;
        if (stream_mismatches() !== 0) begin errors++; $display("FAIL %s stream: got %0d bad bits required 0", tag, stream_mismatches()); end
        checks++;
        if (n_done !== 1) begin errors++; $display("FAIL %s done_count: got %0d required 1", tag, n_done); end
        checks++;
        if (cyc_done !== cyc_last_en + 1) begin errors++; $display("FAIL %s done_latency: got %0d required %0d", tag, cyc_done, cyc_last_en + 1); end
        checks++;
        if (bit_cnt !== CNT_W'(TOTAL)) begin errors++; $display("FAIL %s final_bit_cnt: got %0d required %0d", tag, bit_cnt, TOTAL); end
        checks++;
        if ({prgm_b, clb_prgm_b, chain_en, busy, cfg_ready} !== 5'b10000) begin
            errors++; $display("FAIL %s user_mode_ctl: got %b required 10000", tag, {prgm_b, clb_prgm_b, chain_en, busy, cfg_ready});
        end
        checks++;
        if (n_accepted !== N_ACC) begin errors++; $display("FAIL %s accepted: got %0d required %0d", tag, n_accepted, N_ACC); end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if ({cfg_ready, bit_out, prgm_b, clb_prgm_b, chain_en, busy, done} !== 7'b0010000) begin
            errors++; $display("FAIL reset_ctl: got %b required 0010000", {cfg_ready, bit_out, prgm_b, clb_prgm_b, chain_en, busy, done});
        end
        checks++;
        if (bit_cnt !== '0) begin errors++; $display("FAIL reset_bit_cnt: got %0d required 0", bit_cnt); end
        reset = 1'b0;
        cfg_valid = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (cfg_ready !== 1'b0) begin errors++; $display("FAIL idle_ready: got %b required 0", cfg_ready); end
        cfg_valid = 1'b0;
    endtask

    task automatic test_pattern();
        logic [15:0] lut0;
        build_payload(1);
        run_pass(-1, 0, -1, -1, 0, 0);
        check_good_pass("pattern");
        for (int i = 0; i < 16; i++) lut0[i] = (i < cap_stream.size()) ? cap_stream[i] : 1'b0;
        checks++;
        if (lut0 !== 16'h00FF) begin errors++; $display("FAIL clb0_lut: got %h required 00ff", lut0); end
        checks++;
        if (n_gap !== 0 || cyc_last_en - cyc_first_en + 1 !== TOTAL) begin
            errors++; $display("FAIL pattern_contiguous: got gaps %0d span %0d required 0 and %0d", n_gap, cyc_last_en - cyc_first_en + 1, TOTAL);
        end
    endtask

    task automatic test_underflow();
        logic [15:0] lut_got, lut_exp;
        build_payload(0);
        run_pass(5, 30, -1, -1, 0, 0);
        check_good_pass("underflow");
        checks++;
        if (n_gap < 1 || n_gap > 30) begin errors++; $display("FAIL underflow_gap: got %0d required 1..30", n_gap); end
        checks++;
        if (n_hold_err !== 0) begin errors++; $display("FAIL underflow_hold: got %0d changes required 0", n_hold_err); end
        for (int k = 0; k < NUM_CLB; k++) begin
            for (int i = 0; i < 16; i++) begin
                lut_exp[i] = exp_bit(k * FRAME + i);
                lut_got[i] = (k * FRAME + i < cap_stream.size()) ? cap_stream[k * FRAME + i] : 1'b0;
            end
            checks++;
            if (lut_got !== lut_exp) begin errors++; $display("FAIL clb%0d_lut: got %h required %h", k, lut_got, lut_exp); end
        end
    endtask

    task automatic test_reset_mid();
        build_payload(0);
        run_pass(-1, 0, -1, 20, 0, 0);
        checks++;
        if (rst_hit !== 1'b1) begin errors++; $display("FAIL midreset_reached: got %0d required 1", rst_hit); end
        checks++;
        if (rst_snap_ctl !== 7'b0010000 || rst_snap_cnt !== '0) begin
            errors++; $display("FAIL midreset_outputs: got %b cnt %0d required 0010000 cnt 0", rst_snap_ctl, rst_snap_cnt);
        end
        @(negedge clk) reset = 1'b0;
        @(negedge clk);
        build_payload(0);
        run_pass(-1, 0, -1, -1, 0, 0);
        check_good_pass("after_reset");
    endtask

    task automatic test_start_during_load();
        build_payload(0);
        run_pass(-1, 0, 50, -1, 0, 0);
        check_good_pass("start_in_load");
        checks++;
        if (n_nonmono !== 0) begin errors++; $display("FAIL bit_cnt_monotonic: got %0d decreases required 0", n_nonmono); end
    endtask

    task automatic test_extra_byte();
        build_payload(0);
        run_pass(-1, 0, -1, -1, 1, 0);
        check_good_pass("extra_byte");
        checks++;
        if (cfg_valid !== 1'b0 || cfg_ready !== 1'b0) begin
            errors++; $display("FAIL extra_ready: got valid %b ready %b required 0 0", cfg_valid, cfg_ready);
        end
    endtask

`ifdef CFG_CRC_EN
    task automatic test_crc_err();
        build_payload(0);
        run_pass(-1, 0, -1, -1, 0, 1);
        checks++;
        if (saw_crc_err !== 1'b1 || crc_err !== 1'b1) begin
            errors++; $display("FAIL crc_err_flag: got %b required 1", crc_err);
        end
        checks++;
        if ({prgm_b, clb_prgm_b, busy} !== 3'b000 || n_done !== 0) begin
            errors++; $display("FAIL crc_err_ctl: got %b done %0d required 000 done 0", {prgm_b, clb_prgm_b, busy}, n_done);
        end
        run_pass(-1, 0, -1, -1, 0, 0);
        check_good_pass("crc_retry");
        checks++;
        if (crc_err !== 1'b0) begin errors++; $display("FAIL crc_retry_flag: got %b required 0", crc_err); end
    endtask
`endif

    initial begin
        test_reset();
        test_pattern();
        test_underflow();
        test_reset_mid();
        test_start_during_load();
        test_extra_byte();
`ifdef CFG_CRC_EN
        test_crc_err();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
